// File: rtl/fifo_uart_tx.sv
// ============================================================================
// fifo_uart_tx: pops FIFO words and serializes each as start/data/parity/stop.
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_EN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  par_en_lat;
  logic                  tx_q;
  logic                  tx_nxt;
  logic                  pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tx_q  <= tx_nxt;
    end
  end

  // Popping is only legal between frames; gating with RST keeps the strobe low in reset.
  always_comb begin
    pop       = RST & TX_EN & ~FIFO_EMPTY & ((state == S_IDLE) | (state == S_STOP));
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:   if (pop) state_nxt = S_START;
      S_START: begin
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          state_nxt = par_en_lat ? S_PARITY : S_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = pop ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // TX_OUT is registered, so it is derived from the state being entered.
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg[cnt_nxt];
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en_lat <= 1'b0;
    end else if (pop) begin
      shreg      <= FIFO_RD_DATA;
      par_bit    <= (^FIFO_RD_DATA) ^ PAR_TYP;
      par_en_lat <= PAR_EN;
    end
  end

  assign FIFO_R_INC = pop;
  assign TX_OUT     = tx_q;
  assign BUSY       = (state != S_IDLE);

endmodule

`default_nettype wire
